dir_input_ctrl: RTL and testbench

//   Parametrised per-player direction input controller for the snake game.

---
 rtl/dir_pkg.sv | 43 ++++
 rtl/button_debouncer.sv | 55 +++++
 rtl/dir_input_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_dir_input_ctrl.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/dir_pkg.sv
`default_nettype none
// ============================================================================
// Module  : dir_pkg
// Brief   : Direction and stage codes shared by the direction input controller.
// Revision: 1.0  initial release
// ============================================================================
package dir_pkg;

    typedef enum logic [2:0] {
        DIR_NONE  = 3'd0,
        DIR_UP    = 3'd1,
        DIR_RIGHT = 3'd2,
        DIR_DOWN  = 3'd3,
        DIR_LEFT  = 3'd4
    } dir_t;

    localparam dir_t DIR_RESET = DIR_RIGHT;

    localparam logic [1:0] STG_IDLE = 2'd0;
    localparam logic [1:0] STG_MENU = 2'd1;
    localparam logic [1:0] STG_PLAY = 2'd2;

    function automatic dir_t opposite(input dir_t dir);
        case (dir)
            DIR_UP:    return DIR_DOWN;
            DIR_DOWN:  return DIR_UP;
            DIR_RIGHT: return DIR_LEFT;
            DIR_LEFT:  return DIR_RIGHT;
            default:   return DIR_NONE;
        endcase
    endfunction

    // Button group order is {left,down,right,up}; up has the highest priority.
    function automatic dir_t press_to_dir(input logic [3:0] evt);
        if (evt[0])      return DIR_UP;
        else if (evt[1]) return DIR_RIGHT;
        else if (evt[2]) return DIR_DOWN;
        else if (evt[3]) return DIR_LEFT;
        else             return DIR_NONE;
    endfunction

endpackage
`default_nettype wire

// File: rtl/button_debouncer.sv
`default_nettype none
// ============================================================================
// Module  : button_debouncer
// Brief   : One active-low button: 2-FF synchroniser, stability counter and
//           registered released->pressed event pulse.
// Revision: 1.0  initial release
// ============================================================================
module button_debouncer #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic clock,
    input  logic resetn,
    input  logic i_btn_n,
    output logic o_press
);

    localparam int              CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0] C_CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic             r_state;
    logic             r_state_q;
    logic             r_press;
    logic [CNT_W-1:0] r_cnt;

    // r_state holds the debounced raw level (1 = released).
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_state   <= 1'b1;
            r_state_q <= 1'b1;
            r_press   <= 1'b0;
            r_cnt     <= '0;
        end else begin
            r_sync1   <= i_btn_n;
            r_sync2   <= r_sync1;
            r_state_q <= r_state;
            r_press   <= r_state_q & ~r_state;
            if (r_sync2 == r_state) begin
                r_cnt <= '0;
            end else if (r_cnt == C_CNT_LAST) begin
                r_state <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_press = r_press;

endmodule
`default_nettype wire

// File: rtl/dir_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : dir_input_ctrl
// Brief   : Per-player debounced direction input with no-reversal rules and
//           tick-committed turn buffering. Define KEY_QUEUE_EN for a 2-deep
//           pending FIFO per player (default: single pending register).
// Revision: 1.0  initial release
// ============================================================================
module dir_input_ctrl
    import dir_pkg::*;
#(
    parameter int NUM_PLAYERS     = 2,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int MOVE_W          = 32
) (
    input  logic                          clock,
    input  logic                          resetn,
    input  logic [4*NUM_PLAYERS-1:0]      btn_n,
    input  logic [1:0]                    stage,
    input  logic                          tick,
    input  logic                          game_reset,
    output logic [MOVE_W*NUM_PLAYERS-1:0] move_out,
    output logic [NUM_PLAYERS-1:0]        turn_valid,
    output logic                          any_press
);

    logic [4*NUM_PLAYERS-1:0] w_press;
    logic [1:0]               r_stage_q;
    logic                     w_stage_chg;

    for (genvar i = 0; i < 4*NUM_PLAYERS; i++) begin : g_btn
        button_debouncer #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_deb (
            .clock   (clock),
            .resetn  (resetn),
            .i_btn_n (btn_n[i]),
            .o_press (w_press[i])
        );
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) r_stage_q <= STG_IDLE;
        else         r_stage_q <= stage;
    end

    assign w_stage_chg = (stage != r_stage_q);
    assign any_press   = |w_press;

    for (genvar p = 0; p < NUM_PLAYERS; p++) begin : g_player
        dir_t r_move;
        logic r_turn;
        dir_t w_move_nxt;
        logic w_turn_nxt;
        dir_t w_dir;
        dir_t w_ref;
        logic w_has;
        logic w_accept;
        logic w_pop;
        logic w_clear;
`ifdef KEY_QUEUE_EN
        dir_t       r_q0;
        dir_t       r_q1;
        logic [1:0] r_cnt;
        dir_t       w_q0_nxt;
        dir_t       w_q1_nxt;
        logic [1:0] w_cnt_nxt;
`else
        dir_t r_pend;
        logic r_pvalid;
        dir_t w_pend_nxt;
        logic w_pvalid_nxt;
`endif

        always_comb begin
            w_dir      = press_to_dir(w_press[4*p +: 4]);
            w_has      = |w_press[4*p +: 4];
            w_move_nxt = r_move;
            w_turn_nxt = 1'b0;
            w_accept   = 1'b0;
            w_pop      = 1'b0;
            w_clear    = 1'b0;
`ifdef KEY_QUEUE_EN
            w_ref      = (r_cnt == 2'd2) ? r_q1 : (r_cnt == 2'd1) ? r_q0 : r_move;
            w_q0_nxt   = r_q0;
            w_q1_nxt   = r_q1;
            w_cnt_nxt  = r_cnt;
`else
            // With a tick the pending entry becomes move_out, so it is the reference.
            w_ref        = (tick && r_pvalid) ? r_pend : r_move;
            w_pend_nxt   = r_pend;
            w_pvalid_nxt = r_pvalid;
`endif
            if (game_reset) begin
                w_move_nxt = DIR_RESET;
                w_clear    = 1'b1;
            end else if (stage == STG_MENU) begin
                w_clear = 1'b1;
                if (w_has) begin
                    w_move_nxt = w_dir;
                    w_turn_nxt = 1'b1;
                end
            end else if (stage == STG_PLAY && !w_stage_chg) begin
                w_accept = w_has && (w_dir != w_ref) && (w_dir != opposite(w_ref));
`ifdef KEY_QUEUE_EN
                w_pop = tick && (r_cnt != 2'd0);
                if (w_pop) begin
                    w_move_nxt = r_q0;
                    w_turn_nxt = 1'b1;
                end
                case ({w_pop, w_accept})
                    2'b10: begin
                        w_q0_nxt  = r_q1;
                        w_cnt_nxt = r_cnt - 2'd1;
                    end
                    2'b01: begin
                        if (r_cnt == 2'd0) begin
                            w_q0_nxt  = w_dir;
                            w_cnt_nxt = 2'd1;
                        end else begin
                            w_q1_nxt  = w_dir;
                            w_cnt_nxt = 2'd2;
                        end
                    end
                    2'b11: begin
                        if (r_cnt == 2'd1) begin
                            w_q0_nxt = w_dir;
                        end else begin
                            w_q0_nxt = r_q1;
                            w_q1_nxt = w_dir;
                        end
                    end
                    default: ;
                endcase
`else
                w_pop = tick && r_pvalid;
                if (w_pop) begin
                    w_move_nxt = r_pend;
                    w_turn_nxt = 1'b1;
                end
                if (w_accept) begin
                    w_pend_nxt   = w_dir;
                    w_pvalid_nxt = 1'b1;
                end else if (w_pop) begin
                    w_pvalid_nxt = 1'b0;
                end
`endif
            end else begin
                w_clear = 1'b1;
            end

            if (w_clear) begin
`ifdef KEY_QUEUE_EN
                w_cnt_nxt = 2'd0;
`else
                w_pvalid_nxt = 1'b0;
`endif
            end
        end

        always_ff @(posedge clock or negedge resetn) begin
            if (!resetn) begin
                r_move   <= DIR_RESET;
                r_turn   <= 1'b0;
`ifdef KEY_QUEUE_EN
                r_q0     <= DIR_RESET;
                r_q1     <= DIR_RESET;
                r_cnt    <= 2'd0;
`else
                r_pend   <= DIR_RESET;
                r_pvalid <= 1'b0;
`endif
            end else begin
                r_move   <= w_move_nxt;
                r_turn   <= w_turn_nxt;
`ifdef KEY_QUEUE_EN
                r_q0     <= w_q0_nxt;
                r_q1     <= w_q1_nxt;
                r_cnt    <= w_cnt_nxt;
`else
                r_pend   <= w_pend_nxt;
                r_pvalid <= w_pvalid_nxt;
`endif
            end
        end

        assign move_out[p*MOVE_W +: MOVE_W] = MOVE_W'(r_move);
        assign turn_valid[p]                = r_turn;
    end

endmodule
`default_nettype wire

// File: tb/tb_dir_input_ctrl.sv
`default_nettype none
// ============================================================================
// Module  : tb_dir_input_ctrl
// Brief   : Directed self-checking bench; committed turns are checked against
//           a queue of expected {player, direction} entries.
// Revision: 1.0  initial release
// ============================================================================
module tb_dir_input_ctrl;

    localparam int NP = 4;
    localparam int DB = 4;
    localparam int MW = 32;

    logic            clock      = 1'b0;
    logic            resetn     = 1'b0;
    logic [4*NP-1:0] btn_n      = '1;
    logic [1:0]      stage      = 2'd0;
    logic            tick       = 1'b0;
    logic            game_reset = 1'b0;
    logic [MW*NP-1:0] move_out;
    logic [NP-1:0]   turn_valid;
    logic            any_press;

    dir_input_ctrl #(
        .NUM_PLAYERS     (NP),
        .DEBOUNCE_CYCLES (DB),
        .MOVE_W          (MW)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .btn_n      (btn_n),
        .stage      (stage),
        .tick       (tick),
        .game_reset (game_reset),
        .move_out   (move_out),
        .turn_valid (turn_valid),
        .any_press  (any_press)
    );

    always #5 clock = ~clock;

    typedef struct {
        int          p;
        logic [31:0] d;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;
    int   n_any  = 0;

    task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] mv(input int p);
        return move_out[p*MW +: MW];
    endfunction

    task automatic step(input int n);
        repeat (n) @(negedge clock);
    endtask

    task automatic press(input logic [4*NP-1:0] mask);
        btn_n = ~mask;
        step(8);
        btn_n = '1;
        step(10);
    endtask

    task automatic pulse_tick();
        tick = 1'b1;
        step(1);
        tick = 1'b0;
    endtask

    task automatic pulse_grst();
        game_reset = 1'b1;
        step(1);
        game_reset = 1'b0;
    endtask

    // Every turn_valid pulse must match the oldest expected commit.
    always @(negedge clock) begin
        exp_t e;
        if (any_press === 1'b1) n_any++;
        for (int p = 0; p < NP; p++) begin
            if (turn_valid[p] !== 1'b0) begin
                if (sb.size() == 0) begin
                    chk($sformatf("unexpected_turn_p%0d", p), 128'(mv(p)), 128'(0));
                end else begin
                    e = sb.pop_front();
                    chk("turn_player", 128'(p), 128'(e.p));
                    chk("turn_move", 128'(mv(p)), 128'(e.d));
                end
            end
        end
    end

    initial begin
        step(2);
        chk("rst_move", 128'(move_out), {NP{32'd2}});
        chk("rst_turn", 128'(turn_valid), 128'(0));
        chk("rst_any", 128'(any_press), 128'(0));

        resetn = 1'b1;
        stage  = 2'd2;
        step(3);

        // Three low samples then release: too short to register.
        btn_n[0] = 1'b0;
        step(3);
        btn_n[0] = 1'b1;
        step(12);
        chk("glitch_any", 128'(n_any), 128'(0));
        pulse_tick();
        chk("glitch_move", 128'(mv(0)), 128'(2));

        // Press event appears DB+2 edges after the first sampling edge.
        btn_n[0] = 1'b0;
        for (int i = 1; i <= 6; i++) begin
            step(1);
            chk($sformatf("lat_early_%0d", i), 128'(any_press), 128'(0));
        end
        step(1);
        chk("lat_hit", 128'(any_press), 128'(1));
        step(1);
        chk("lat_pulse_end", 128'(any_press), 128'(0));
        step(2);
        btn_n[0] = 1'b1;
        step(10);
        chk("pend_no_commit", 128'(mv(0)), 128'(2));
        sb.push_back('{0, 32'd1});
        pulse_tick();
        chk("tick_up", 128'(mv(0)), 128'(1));

        // Reversal rejected in play; accepted immediately in menu.
        pulse_grst();
        chk("grst_move", 128'(mv(0)), 128'(2));
        press(16'h0008);
        pulse_tick();
        chk("rev_reject", 128'(mv(0)), 128'(2));
        stage = 2'd1;
        step(2);
        sb.push_back('{0, 32'd4});
        press(16'h0008);
        chk("menu_left", 128'(mv(0)), 128'(4));

        // Up then left within one tick interval.
        stage = 2'd2;
        pulse_grst();
        step(2);
        press(16'h0001);
        press(16'h0008);
`ifdef KEY_QUEUE_EN
        sb.push_back('{0, 32'd1});
        pulse_tick();
        chk("fifo_first", 128'(mv(0)), 128'(1));
        sb.push_back('{0, 32'd4});
        pulse_tick();
        chk("fifo_second", 128'(mv(0)), 128'(4));
`else
        // Single-register mode checks reversal against move_out (right), so left is dropped.
        sb.push_back('{0, 32'd1});
        pulse_tick();
        chk("single_first", 128'(mv(0)), 128'(1));
        pulse_tick();
        chk("single_empty", 128'(mv(0)), 128'(1));
        pulse_grst();
        press(16'h0001);
        press(16'h0004);
        sb.push_back('{0, 32'd3});
        pulse_tick();
        chk("single_overwrite", 128'(mv(0)), 128'(3));
`endif

        // Simultaneous up+right: up wins.
        pulse_grst();
        stage = 2'd1;
        step(2);
        sb.push_back('{0, 32'd1});
        press(16'h0003);
        chk("prio_up", 128'(mv(0)), 128'(1));

        // game_reset overrides a tick with a pending down.
        stage = 2'd2;
        pulse_grst();
        step(2);
        press(16'h0004);
        game_reset = 1'b1;
        tick       = 1'b1;
        step(1);
        game_reset = 1'b0;
        tick       = 1'b0;
        chk("grst_tick_move", 128'(mv(0)), 128'(2));
        pulse_tick();
        chk("grst_pend_clear", 128'(mv(0)), 128'(2));

        // Four players at once: up, down, left (reversal), right (same).
        press(16'h2841);
        sb.push_back('{0, 32'd1});
        sb.push_back('{1, 32'd3});
        pulse_tick();
        chk("multi_player", 128'(move_out), {32'd2, 32'd2, 32'd3, 32'd1});

        // Stage round-trip discards pending.
        press(16'h0002);
        stage = 2'd0;
        step(2);
        stage = 2'd2;
        step(2);
        pulse_tick();
        chk("stage_clear", 128'(mv(0)), 128'(1));

        // Asynchronous reset between clock edges.
        #2;
        resetn = 1'b0;
        #1;
        chk("async_rst_move", 128'(move_out), {NP{32'd2}});
        chk("async_rst_turn", 128'(turn_valid), 128'(0));
        step(2);
        resetn = 1'b1;
        step(2);

        chk("sb_empty", 128'(sb.size()), 128'(0));
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
